hiscore_ram_arbiter: RTL and testbench

// Shares one game work-RAM port between the core CPU and the nvram hiscore extractor.

---
 rtl/hiscore_ram_arbiter.sv | 116 +++++++++++
 tb/tb_hiscore_ram_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hiscore_ram_arbiter.sv
// hiscore_ram_arbiter: shares one work-RAM port between the CPU and the hiscore extractor; optional REQ timeout under HS_ARB_TIMEOUT_EN
module hiscore_ram_arbiter #(
    parameter int AW       = 8,
    parameter int IDLEHOLD = 2,
    parameter int GUARD    = 4,
    parameter int TIMEOUT  = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pause_req,
    output logic          paused,
    input  logic [AW-1:0] nv_addr,
    output logic [7:0]    nv_data,
    output logic          cpu_pause,
    input  logic          cpu_idle,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout,
    output logic          error
);
    localparam int IH = IDLEHOLD < 1 ? 1 : IDLEHOLD;
    localparam int GD = GUARD < 1 ? 0 : GUARD - 1;
    localparam int IW = $clog2(IH + 1);
    localparam int GW = $clog2(GD + 2);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_OWN, S_GUARD} state_t;
    state_t state, state_n;
    logic [IW-1:0] idle_cnt, idle_n;
    logic [GW-1:0] guard_cnt, guard_n;
    logic req, grant, tmo;
    assign grant = cpu_idle && idle_cnt == IW'(IH - 1);
`ifdef HS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt, to_n;
    logic armed, err_q;
    assign req   = pause_req && armed;
    assign tmo   = state == S_REQ && req && !grant && to_cnt == TW'(TIMEOUT - 1);
    assign to_n  = (state == S_REQ && state_n == S_REQ) ? to_cnt + TW'(to_cnt != TW'(TIMEOUT - 1)) : '0;
    assign error = err_q;
    // timeout counter, sticky error, and re-arm after pause_req is seen low
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
            armed  <= 1'b1;
        end else begin
            to_cnt <= to_n;
            err_q  <= err_q | tmo;
            armed  <= !pause_req ? 1'b1 : (tmo ? 1'b0 : armed);
        end
    end
`else
    assign req   = pause_req;
    assign tmo   = 1'b0;
    assign error = 1'b0;
`endif
    // state and counter registers; read data always captured for the extractor
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idle_cnt  <= '0;
            guard_cnt <= '0;
            nv_data   <= '0;
        end else begin
            state     <= state_n;
            idle_cnt  <= idle_n;
            guard_cnt <= guard_n;
            nv_data   <= ram_dout;
        end
    end
    // next state: request handshake, idle qualification, guard countdown
    always_comb begin
        state_n = state;
        idle_n  = idle_cnt;
        guard_n = guard_cnt;
        case (state)
            S_IDLE: if (req) begin
                state_n = S_REQ;
                idle_n  = '0;
            end
            S_REQ: if (!req || tmo) begin
                state_n = S_GUARD;
                guard_n = GW'(GD);
            end else if (grant) begin
                state_n = S_OWN;
            end else begin
                idle_n = cpu_idle ? idle_cnt + IW'(idle_cnt != IW'(IH - 1)) : '0;
            end
            S_OWN: if (!req) begin
                state_n = S_GUARD;
                guard_n = GW'(GD);
            end
            default: if (req) begin
                state_n = S_REQ;
                idle_n  = '0;
            end else if (guard_cnt == '0) begin
                state_n = S_IDLE;
            end else begin
                guard_n = guard_cnt - 1'b1;
            end
        endcase
    end
    // outputs decoded from the state register; port returns to the CPU while reset is held
    always_comb begin
        paused    = state == S_OWN;
        cpu_pause = state != S_IDLE;
        ram_addr  = (paused && !reset) ? nv_addr : cpu_addr;
        ram_we    = (paused && !reset) ? 1'b0 : cpu_we;
        ram_din   = (paused && !reset) ? 8'h00 : cpu_din;
        cpu_dout  = ram_dout;
    end
endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// tb_hiscore_ram_arbiter: vector table plus scoreboard checks of the hiscore RAM arbiter
module tb_hiscore_ram_arbiter;
    localparam logic H = 1'b1, L = 1'b0;
    logic clk = 0, reset = 1, pause_req = 0, cpu_idle = 1, cpu_we = 0;
    logic [7:0] nv_addr = 0, cpu_addr = 0, cpu_din = 0;
    logic paused, cpu_pause, ram_we, error;
    logic [7:0] nv_data, cpu_dout, ram_addr, ram_din;
    logic [7:0] ram_dout = 0;
    logic [7:0] mem [256];
    int n_chk = 0, n_fail = 0;

    typedef struct {logic rst, preq, idle, cp, pd;} vec_t;
    typedef struct {logic cp, pd; logic [7:0] addr;} sb_t;
    vec_t tv [29];
    sb_t q [$];
    logic [7:0] bq [$];

    hiscore_ram_arbiter #(.AW(8), .IDLEHOLD(2), .GUARD(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .pause_req(pause_req), .paused(paused),
        .nv_addr(nv_addr), .nv_data(nv_data), .cpu_pause(cpu_pause), .cpu_idle(cpu_idle),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input string nm, input logic sel, input logic val);
        for (int k = 0; k < 20; k++) begin
            if ((sel ? paused : cpu_pause) === val) break;
            tick();
        end
        chk(nm, {7'd0, sel ? paused : cpu_pause}, {7'd0, val});
    endtask

    initial begin
        sb_t e;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h3c);
        mem[8'h12] = 8'ha5;
        mem[8'h30] = 8'h5a;
        tv = '{
            '{H,L,H,L,L}, '{L,L,H,L,L}, '{L,H,H,H,L}, '{L,H,H,H,L}, '{L,H,H,H,H},
            '{L,H,H,H,H}, '{L,L,H,H,L}, '{L,L,H,H,L}, '{L,L,H,H,L}, '{L,L,H,H,L},
            '{L,L,H,L,L}, '{L,H,H,H,L}, '{L,H,H,H,L}, '{L,H,L,H,L}, '{L,H,H,H,L},
            '{L,H,H,H,H}, '{L,L,H,H,L}, '{L,H,L,H,L}, '{L,H,L,H,L}, '{L,L,L,H,L},
            '{L,L,L,H,L}, '{L,L,L,H,L}, '{L,L,L,H,L}, '{L,L,L,L,L}, '{L,H,H,H,L},
            '{L,H,H,H,L}, '{L,H,H,H,H}, '{H,H,H,L,L}, '{L,L,H,L,L}
        };
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            reset     = tv[i].rst;
            pause_req = tv[i].preq;
            cpu_idle  = tv[i].idle;
            cpu_addr  = 8'(8'h40 + i);
            nv_addr   = 8'(8'h80 + i);
            q.push_back('{tv[i].cp, tv[i].pd, tv[i].pd ? nv_addr : cpu_addr});
            if (tv[i].rst && i > 0 && tv[i-1].pd) begin
                #1;
                chk("reset_mux", ram_addr, cpu_addr);
            end
            tick();
            e = q.pop_front();
            chk($sformatf("cpu_pause[%0d]", i), {7'd0, cpu_pause}, {7'd0, e.cp});
            chk($sformatf("paused[%0d]", i), {7'd0, paused}, {7'd0, e.pd});
            chk($sformatf("ram_addr[%0d]", i), ram_addr, e.addr);
            if (tv[i].rst) chk($sformatf("nv_data_rst[%0d]", i), nv_data, 8'h00);
        end

        // extractor read while owning the port; CPU write must be dropped
        @(negedge clk);
        pause_req = 1; cpu_idle = 1;
        tick();
        wait_sig("own_grant", 1'b1, 1'b1);
        @(negedge clk);
        nv_addr = 8'h12; cpu_addr = 8'h30; cpu_we = 1; cpu_din = 8'h77;
        bq.push_back(8'ha5);
        #1;
        chk("own_ram_we", {7'd0, ram_we}, 8'h00);
        chk("own_ram_din", ram_din, 8'h00);
        tick();
        chk("cpu_dout", cpu_dout, 8'ha5);
        tick();
        chk("nv_data_read", nv_data, bq.pop_front());
        @(negedge clk);
        cpu_we = 0; pause_req = 0;
        tick();
        chk("release_paused", {7'd0, paused}, 8'h00);
        wait_sig("release_cpu_pause", 1'b0, 1'b0);
        chk("own_write_dropped", mem[8'h30], 8'h5a);
        chk("release_mux", ram_addr, cpu_addr);

        // CPU busy in REQ: writes pass through, no grant
        @(negedge clk);
        pause_req = 1; cpu_idle = 0; cpu_addr = 8'h31; cpu_we = 1; cpu_din = 8'hc3;
        tick();
        chk("req_ram_we", {7'd0, ram_we}, 8'h01);
        chk("req_ram_din", ram_din, 8'hc3);
        repeat (6) tick();
        chk("req_busy_no_grant", {7'd0, paused}, 8'h00);
        chk("req_busy_cpu_pause", {7'd0, cpu_pause}, 8'h01);
        @(negedge clk);
        cpu_we = 0; pause_req = 0;
        tick();
        chk("req_write_passed", mem[8'h31], 8'hc3);
        wait_sig("abort_cpu_pause", 1'b0, 1'b0);

`ifdef HS_ARB_TIMEOUT_EN
        @(negedge clk);
        pause_req = 1; cpu_idle = 0;
        tick();
        repeat (15) tick();
        chk("tmo_not_yet", {7'd0, error}, 8'h00);
        tick();
        chk("tmo_error", {7'd0, error}, 8'h01);
        repeat (5) tick();
        chk("tmo_release", {7'd0, cpu_pause}, 8'h00);
        repeat (3) tick();
        chk("tmo_ignored_req", {7'd0, cpu_pause}, 8'h00);
        chk("tmo_sticky", {7'd0, error}, 8'h01);
        @(negedge clk);
        reset = 1; pause_req = 0;
        tick();
        chk("tmo_reset", {7'd0, error}, 8'h00);
        @(negedge clk);
        reset = 0;
`else
        chk("error_tied", {7'd0, error}, 8'h00);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
